// File: rtl/alu_exec_ctrl.sv
// Execute-stage ALU for the LEGv8 datapath with built-in ALU-control decode.
// Single-cycle ops return one cycle after accept. MUL runs on an iterative
// shift-add engine. Results are held on a valid/ready output until taken.
module alu_exec_ctrl #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6,
    parameter bit MUL_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [10:0]        opcode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [3:0]         op_code,
    output logic               illegal,
    output logic               busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ORR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e             state;
    state_e             state_next;
    logic [3:0]         dec_code;
    logic               accept;
    logic               mul_done;
    logic               sub_sel;
    logic               shift_oob;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   count;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == S_MUL);
    assign mul_done = (state == S_MUL) && (count == CNT_W'(1));

    // ALU-control decode: ALUOp plus the R-type opcode to a 4-bit operation code.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_code = OP_ILL;
        case (alu_op)
            2'b00:   dec_code = OP_ADD;
            2'b01:   dec_code = OP_PASS;
            default: begin
                case (opcode)
                    11'b10001011000: dec_code = OP_ADD;
                    11'b11001011000: dec_code = OP_SUB;
                    11'b10001010000: dec_code = OP_AND;
                    11'b10101010000: dec_code = OP_ORR;
                    11'b11010011011: dec_code = OP_LSL;
                    11'b11010011010: dec_code = OP_LSR;
                    11'b10011011000: dec_code = MUL_EN ? OP_MUL : OP_ILL;
                    default:         dec_code = OP_ILL;
                endcase
            end
        endcase
    end

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        sub_sel   = (dec_code == OP_SUB);
        b_eff     = sub_sel ? ~op_b : op_b;
        shift_oob = (32'(shamt) >= 32'(WIDTH));
        alu_res   = '0;
        case (dec_code)
            OP_AND:         alu_res = op_a & op_b;
            OP_ORR:         alu_res = op_a | op_b;
            OP_ADD, OP_SUB: alu_res = op_a + b_eff + WIDTH'(sub_sel);
            OP_LSL:         alu_res = shift_oob ? '0 : (op_a << shamt);
            OP_LSR:         alu_res = shift_oob ? '0 : (op_a >> shamt);
            OP_PASS:        alu_res = op_b;
            default:        alu_res = '0;
        endcase
    end

    // Next accumulator value of the shift-add multiplier.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
    end

    // FSM next-state: leave IDLE on a MUL accept, return after the last step.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && dec_code == OP_MUL) state_next = S_MUL;
            S_MUL:   if (count == CNT_W'(1))           state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Multiplier engine registers: load on MUL accept, shift each MUL cycle.
    always_ff @(posedge clk) begin
        // NOTE: engine registers carry no reset; they are only read while state is MUL, which reset clears.
        if (accept && dec_code == OP_MUL) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            count  <= CNT_W'(WIDTH);
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
        end
    end

    // Output register: pop on out_ready, load a single-cycle result or a finished MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            op_code   <= 4'b0000;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && dec_code != OP_MUL) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                op_code   <= dec_code;
                illegal   <= (dec_code == OP_ILL);
            end else if (mul_done) begin
                out_valid <= 1'b1;
                result    <= acc_next;
                zero      <= (acc_next == '0);
                op_code   <= OP_MUL;
                illegal   <= 1'b0;
            end
        end
    end

endmodule
